// File: rtl/switch_control.sv
// switch_control: central switch allocator for a Phoenix router.
// Arbitrates header requests, latches the winning header, computes the XY route,
// and grants the output if it is free. Crossbar tables are held until the input
// releases the connection.
// Build option: define SC_ROUND_ROBIN_EN for rotating priority; otherwise the
// lowest requesting index always wins.
// Ports use i_/o_ prefixes ("release" is a reserved word in SystemVerilog).
module switch_control #(
  parameter int NPORT = 5,
  parameter int WIDTH = 8,
  parameter int SELW  = 3
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [WIDTH-1:0]       i_address,
  input  logic [NPORT-1:0]       i_h,
  input  logic [NPORT*WIDTH-1:0] i_data_in,
  input  logic [NPORT-1:0]       i_release,
  output logic [NPORT-1:0]       o_ack_h,
  output logic [NPORT-1:0]       o_in_connected,
  output logic [NPORT-1:0]       o_enable_out,
  output logic [NPORT*SELW-1:0]  o_mux_in,
  output logic [NPORT*SELW-1:0]  o_mux_out
);
  localparam int HW = WIDTH / 2;
  localparam logic [SELW-1:0] P_EAST  = SELW'(0);
  localparam logic [SELW-1:0] P_WEST  = SELW'(1);
  localparam logic [SELW-1:0] P_NORTH = SELW'(2);
  localparam logic [SELW-1:0] P_SOUTH = SELW'(3);
  localparam logic [SELW-1:0] P_LOCAL = SELW'(4);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hdr;
  logic [SELW-1:0]  r_sel;
`ifdef SC_ROUND_ROBIN_EN
  logic [SELW-1:0]  r_ptr;
`endif

  logic [NPORT-1:0] w_elig;
  logic [NPORT-1:0] w_rel;
  logic [NPORT-1:0] w_en_clr;
  logic [SELW:0]    w_arb;
  logic             w_any;
  logic [SELW-1:0]  w_pick;
  logic [SELW-1:0]  w_dest;
  logic [HW-1:0]    w_tx, w_ty, w_lx, w_ly;

  // First set bit of e found by walking upward (with wrap) from start.
  // Returns {found, index}.
  function automatic logic [SELW:0] first_elig(input logic [NPORT-1:0] e, input int start);
    logic [SELW:0] res;
    int            idx;
    res = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = (start + k) % NPORT;
      if (e[idx]) res = {1'b1, SELW'(idx)};
    end
    return res;
  endfunction

  // A connected input's header request is ignored until it releases
  assign w_elig = i_h & ~o_in_connected;
  assign w_rel  = i_release & o_in_connected;

`ifdef SC_ROUND_ROBIN_EN
  assign w_arb = first_elig(w_elig, int'(r_ptr) + 1);
`else
  assign w_arb = first_elig(w_elig, 0);
`endif
  assign w_any  = w_arb[SELW];
  assign w_pick = w_arb[SELW-1:0];

  assign w_tx = r_hdr[WIDTH-1:HW];
  assign w_ty = r_hdr[HW-1:0];
  assign w_lx = i_address[WIDTH-1:HW];
  assign w_ly = i_address[HW-1:0];

  // XY routing: resolve X first, then Y, otherwise deliver locally
  always_comb begin
    w_dest = P_LOCAL;
    if      (w_tx > w_lx) w_dest = P_EAST;
    else if (w_tx < w_lx) w_dest = P_WEST;
    else if (w_ty > w_ly) w_dest = P_NORTH;
    else if (w_ty < w_ly) w_dest = P_SOUTH;
  end

  // Outputs freed by releasing inputs, found through their stored destination
  always_comb begin
    w_en_clr = '0;
    for (int i = 0; i < NPORT; i++)
      if (w_rel[i]) w_en_clr[o_mux_out[i*SELW +: SELW]] = 1'b1;
  end

  // Allocator FSM. Releases apply in every state; a grant in the same edge
  // is written later in the block, so it overrides a release of the same bit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_hdr          <= '0;
      r_sel          <= '0;
`ifdef SC_ROUND_ROBIN_EN
      r_ptr          <= SELW'(NPORT - 1);
`endif
      o_ack_h        <= '0;
      o_in_connected <= '0;
      o_enable_out   <= '0;
      o_mux_in       <= '0;
      o_mux_out      <= '0;
    end else begin
      o_ack_h        <= '0;
      o_in_connected <= o_in_connected & ~w_rel;
      o_enable_out   <= o_enable_out & ~w_en_clr;
      case (r_state)
        S_IDLE: if (|w_elig) r_state <= S_ARB;
        S_ARB: begin
          if (w_any) begin
            r_hdr   <= i_data_in[w_pick*WIDTH +: WIDTH];
            r_sel   <= w_pick;
`ifdef SC_ROUND_ROBIN_EN
            r_ptr   <= w_pick;
`endif
            r_state <= S_ROUTE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ROUTE: begin
          // Busy output: drop back; the moved pointer lets others go first
          if (!o_enable_out[w_dest]) begin
            o_enable_out[w_dest]            <= 1'b1;
            o_in_connected[r_sel]           <= 1'b1;
            o_mux_in[w_dest*SELW +: SELW]   <= r_sel;
            o_mux_out[r_sel*SELW +: SELW]   <= w_dest;
            o_ack_h                         <= NPORT'(1) << r_sel;
            r_state                         <= S_GRANT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_control.sv
// Directed bench for switch_control: reset, latency, XY routing, arbitration
// order, blocked output / release handoff, and mid-transaction reset.
module tb_switch_control;
  localparam int NPORT = 5;
  localparam int WIDTH = 8;
  localparam int SELW  = 3;

  logic                   clk;
  logic                   rst_n;
  logic [WIDTH-1:0]       address;
  logic [NPORT-1:0]       h;
  logic [NPORT*WIDTH-1:0] data_in;
  logic [NPORT-1:0]       rel;
  logic [NPORT-1:0]       ack_h;
  logic [NPORT-1:0]       in_conn;
  logic [NPORT-1:0]       en_out;
  logic [NPORT*SELW-1:0]  mux_in;
  logic [NPORT*SELW-1:0]  mux_out;

  int n_vec = 0;
  int n_err = 0;

  switch_control #(.NPORT(NPORT), .WIDTH(WIDTH), .SELW(SELW)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_address(address), .i_h(h),
    .i_data_in(data_in), .i_release(rel), .o_ack_h(ack_h),
    .o_in_connected(in_conn), .o_enable_out(en_out),
    .o_mux_in(mux_in), .o_mux_out(mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Tick until an ack appears or the budget runs out
  task automatic wait_ack(input int maxc, output int n, output logic [NPORT-1:0] a);
    n = 0;
    a = '0;
    while (n < maxc && a == '0) begin
      tick();
      n++;
      a = ack_h;
    end
  endtask

  task automatic pulse_rel(input logic [NPORT-1:0] r);
    rel = r;
    tick();
    rel = '0;
  endtask

  function automatic logic [SELW-1:0] fld(input logic [NPORT*SELW-1:0] v, input int j);
    return v[j*SELW +: SELW];
  endfunction

  logic [WIDTH-1:0] hdr3 [4];
  int               n;
  logic [NPORT-1:0] a;
  int               ack_seen;

  initial begin
    hdr3[0] = 8'h31; hdr3[1] = 8'h01; hdr3[2] = 8'h13; hdr3[3] = 8'h10;
    rst_n = 1'b0; address = 8'h11; h = '0; data_in = '0; rel = '0;

    // 1: reset holds everything at zero regardless of inputs
    tick();
    h = 5'b11111; rel = 5'b10101; data_in = 40'h1122334455;
    tick(); tick();
    chk("rst_ctl", {ack_h, in_conn, en_out}, 32'h0);
    chk("rst_mux", {mux_in, mux_out}, 32'h0);
    h = '0; rel = '0; data_in = '0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_ctl", {ack_h, in_conn, en_out}, 32'h0);
    chk("idle_mux", {mux_in, mux_out}, 32'h0);

    // 2: single local request, ack exactly in cycle 3
    data_in[0 +: 8] = 8'h11;
    h = 5'b00001;
    tick(); chk("t2_ack_c1", ack_h, 0);
    tick(); chk("t2_ack_c2", ack_h, 0);
    tick();
    chk("t2_ack_c3", ack_h, 5'b00001);
    chk("t2_en", en_out, 5'b10000);
    chk("t2_muxin4", fld(mux_in, 4), 0);
    chk("t2_muxout0", fld(mux_out, 0), 4);
    chk("t2_conn", in_conn, 5'b00001);
    h = '0;
    tick(); chk("t2_ack_c4", ack_h, 0);
    pulse_rel(5'b00001);
    chk("t2_rel_conn", in_conn, 0);
    chk("t2_rel_en", en_out, 0);

    // 3: local input routed by header to each of E/W/N/S
    for (int k = 0; k < 4; k++) begin
      data_in[4*WIDTH +: WIDTH] = hdr3[k];
      h = 5'b10000;
      wait_ack(10, n, a);
      chk($sformatf("t3_ack%0d", k), a, 5'b10000);
      chk($sformatf("t3_lat%0d", k), n, 3);
      chk($sformatf("t3_dst%0d", k), fld(mux_out, 4), k);
      h = '0;
      pulse_rel(5'b10000);
      tick();
    end

    // 4: all inputs request distinct outputs; served 0..4, 4 cycles apart
    data_in = {8'h11, 8'h10, 8'h12, 8'h01, 8'h21};
    h = 5'b11111;
    for (int k = 0; k < NPORT; k++) begin
      wait_ack(12, n, a);
      chk($sformatf("t4_ack%0d", k), a, 5'b00001 << k);
      chk($sformatf("t4_gap%0d", k), n, (k == 0) ? 3 : 4);
    end
    chk("t4_en", en_out, 5'b11111);
    chk("t4_conn", in_conn, 5'b11111);
    h = '0;
    pulse_rel(5'b11111);
    chk("t4_rel", {in_conn, en_out}, 0);
    tick();

    // 5: two inputs contend for LOCAL; loser waits for the release
    data_in = '0;
    data_in[1*WIDTH +: WIDTH] = 8'h11;
    data_in[2*WIDTH +: WIDTH] = 8'h11;
    h = 5'b00110;
    wait_ack(10, n, a);
    chk("t5_ack1", a, 5'b00010);
    chk("t5_lat", n, 3);
    ack_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ack_h != '0) ack_seen++;
    end
    chk("t5_blocked", ack_seen, 0);
    chk("t5_muxin4", fld(mux_in, 4), 1);
    // release on an unconnected input must not free anything
    pulse_rel(5'b10000);
    chk("t5_rel_ign", en_out, 5'b10000);
    h = 5'b00100;
    pulse_rel(5'b00010);
    wait_ack(8, n, a);
    chk("t5_ack2", a, 5'b00100);
    chk("t5_ack2_in8", (n + 1 <= 8) ? 1 : 0, 1);
    chk("t5_muxin4b", fld(mux_in, 4), 2);
    chk("t5_en4", en_out[4], 1);
    h = '0;
    pulse_rel(5'b00100);
    tick();

    // 6: reset in S_ROUTE aborts; after reset the held request is served
    data_in[0 +: 8] = 8'h11;
    h = 5'b00001;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_now", {ack_h, in_conn, en_out}, 0);
    chk("t6_rst_mux", {mux_in, mux_out}, 0);
    ack_seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ack_h != '0) ack_seen++;
    end
    chk("t6_no_ack", ack_seen, 0);
    rst_n = 1'b1;
    wait_ack(10, n, a);
    chk("t6_ack", a, 5'b00001);
    chk("t6_lat", n, 3);
    h = '0;
    pulse_rel(5'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
